// File: rtl/sopc_pio_in_capture_pkg.sv
// Shared constants for the input PIO: Avalon word addresses and edge-select codes.
package sopc_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/sopc_pio_in_capture_if.sv
// Avalon-MM slave bus of the input PIO, with its level interrupt line.
interface sopc_pio_in_capture_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/sopc_pio_in_capture_sync.sv
// Per-bit two-flop synchroniser plus history flop; emits the synchronised level
// and a one-cycle edge pulse of the selected polarity, gated by en.
module pio_edge_sync
    import sopc_pio_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] edge_pulse
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] s3;
    logic [WIDTH-1:0] det;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= in_port;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_comb begin
        det = s2 & ~s3;
        if (EDGE_TYPE == EDGE_FALL) begin
            det = ~s2 & s3;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            det = s2 ^ s3;
        end
    end

    assign level      = s2;
    assign edge_pulse = en ? det : '0;

endmodule

// File: rtl/sopc_pio_in_capture.sv
// Input PIO: synchronised DATA, IRQ_MASK and W1C EDGE_CAPTURE registers behind a
// one-cycle-latency Avalon read port, with a level irq from capture or from level.
module sopc_pio_in_capture
    import sopc_pio_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int EDGE_TYPE = EDGE_RISE,
    parameter int IRQ_LEVEL = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    sopc_pio_in_capture_if.slave  bus,
    input  logic [WIDTH-1:0]      in_port
);

    logic [1:0]       settle_cnt;
    logic             settled;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] clr;
    logic             wr_en;
    logic [31:0]      rd_next;
    logic             unused_wdata;

    assign settled      = (settle_cnt == 2'd3);
    assign wr_en        = bus.chipselect && !bus.write_n;
    assign wdata        = bus.writedata[WIDTH-1:0];
    assign unused_wdata = &{1'b0, bus.writedata};
    assign clr          = (wr_en && bus.address == ADDR_EDGE) ? wdata : '0;

    pio_edge_sync #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_sync (
        .clk        (clk),
        .reset      (reset),
        .en         (settled),
        .in_port    (in_port),
        .level      (level),
        .edge_pulse (edge_pulse)
    );

    // Holds edge detection off until the reset-valued synchroniser flops have flushed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_cnt <= 2'd0;
        end else if (!settled) begin
            settle_cnt <= settle_cnt + 2'd1;
        end
    end

    // A new edge in the same cycle as its W1C keeps the bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            if (wr_en && bus.address == ADDR_MASK) begin
                irq_mask <= wdata;
            end
            edge_cap <= (edge_cap & ~clr) | edge_pulse;
        end
    end

    always_comb begin
        rd_next = '0;
        case (bus.address)
            ADDR_DATA: rd_next[WIDTH-1:0] = level;
            ADDR_MASK: rd_next[WIDTH-1:0] = irq_mask;
            ADDR_EDGE: rd_next[WIDTH-1:0] = edge_cap;
            default:   rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_next;
        end
    end

    generate
        if (IRQ_LEVEL != 0) begin : g_irq_level
            assign bus.irq = |(level & irq_mask);
        end else begin : g_irq_edge
            assign bus.irq = |(edge_cap & irq_mask);
        end
    endgenerate

endmodule

// File: tb/tb_sopc_pio_in_capture.sv
// Directed bench: dut a is rising-edge/capture-irq, dut b is any-edge/level-irq.
module tb_sopc_pio_in_capture;
    import sopc_pio_pkg::*;

    logic       clk;
    logic       reset;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [31:0] v;
    int checks;
    int failures;

    sopc_pio_in_capture_if ia ();
    sopc_pio_in_capture_if ib ();

    sopc_pio_in_capture #(.WIDTH(4), .EDGE_TYPE(EDGE_RISE), .IRQ_LEVEL(0)) dut_a (
        .clk     (clk),
        .reset   (reset),
        .bus     (ia),
        .in_port (in_a)
    );

    sopc_pio_in_capture #(.WIDTH(4), .EDGE_TYPE(EDGE_ANY), .IRQ_LEVEL(1)) dut_b (
        .clk     (clk),
        .reset   (reset),
        .bus     (ib),
        .in_port (in_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wr(input bit sel, input logic [1:0] a, input logic [31:0] d);
        if (sel) begin
            ib.address = a; ib.writedata = d; ib.chipselect = 1'b1; ib.write_n = 1'b0;
        end else begin
            ia.address = a; ia.writedata = d; ia.chipselect = 1'b1; ia.write_n = 1'b0;
        end
        cyc(1);
        ia.chipselect = 1'b0; ia.write_n = 1'b1;
        ib.chipselect = 1'b0; ib.write_n = 1'b1;
    endtask

    task automatic rd(input bit sel, input logic [1:0] a, output logic [31:0] d);
        if (sel) ib.address = a;
        else     ia.address = a;
        cyc(1);
        d = sel ? ib.readdata : ia.readdata;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        in_a = 4'h1;
        in_b = 4'h0;
        ia.address = 2'd3; ia.chipselect = 1'b0; ia.write_n = 1'b1; ia.writedata = '0;
        ib.address = 2'd3; ib.chipselect = 1'b0; ib.write_n = 1'b1; ib.writedata = '0;

        // Reset with in_port high held: nothing captured after release
        cyc(3);
        chk("rst_rdata", ia.readdata, 32'h0);
        chk("rst_irq", {31'h0, ia.irq}, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("settle_irq", {31'h0, ia.irq}, 32'h0);
            chk("settle_cap", ia.readdata, 32'h0);
        end
        rd(1'b0, ADDR_DATA, v);
        chk("data_after_rst", v, 32'h1);

        // Rising-edge capture, W1C, irq
        wr(1'b0, ADDR_MASK, 32'hF);
        in_a = 4'h0;
        cyc(4);
        rd(1'b0, ADDR_EDGE, v);
        chk("fall_ignored", v, 32'h0);
        in_a = 4'h5;
        cyc(1);
        chk("irq_e0", {31'h0, ia.irq}, 32'h0);
        cyc(1);
        chk("irq_e1", {31'h0, ia.irq}, 32'h0);
        cyc(1);
        chk("irq_e2", {31'h0, ia.irq}, 32'h1);
        cyc(1);
        chk("cap_0x5", ia.readdata, 32'h5);
        wr(1'b0, ADDR_EDGE, 32'h1);
        chk("irq_after_w1c1", {31'h0, ia.irq}, 32'h1);
        rd(1'b0, ADDR_EDGE, v);
        chk("cap_0x4", v, 32'h4);
        wr(1'b0, ADDR_EDGE, 32'h4);
        chk("irq_after_w1c4", {31'h0, ia.irq}, 32'h0);
        rd(1'b0, ADDR_EDGE, v);
        chk("cap_clear", v, 32'h0);

        // Mask gating
        wr(1'b0, ADDR_MASK, 32'h0);
        in_a = 4'h0;
        cyc(3);
        in_a = 4'hF;
        cyc(3);
        chk("irq_masked", {31'h0, ia.irq}, 32'h0);
        rd(1'b0, ADDR_EDGE, v);
        chk("cap_0xf", v, 32'hF);
        rd(1'b0, ADDR_MASK, v);
        chk("mask_rd0", v, 32'h0);
        wr(1'b0, ADDR_MASK, 32'h4);
        chk("irq_mask4", {31'h0, ia.irq}, 32'h1);

        // Set/clear collision on bit 0
        in_a = 4'h0;
        cyc(3);
        in_a = 4'h1;
        cyc(2);
        wr(1'b0, ADDR_EDGE, 32'h1);
        rd(1'b0, ADDR_EDGE, v);
        chk("collision_set_wins", v, 32'hF);
        wr(1'b0, ADDR_EDGE, 32'h1);
        rd(1'b0, ADDR_EDGE, v);
        chk("w1c_bit0", v, 32'hE);
        chk("irq_bit2", {31'h0, ia.irq}, 32'h1);

        // Any-edge capture with level irq
        wr(1'b1, ADDR_MASK, 32'h2);
        ib.address = ADDR_EDGE;
        in_b = 4'h2;
        cyc(1);
        chk("lvl_irq_e0", {31'h0, ib.irq}, 32'h0);
        cyc(1);
        chk("lvl_irq_e1", {31'h0, ib.irq}, 32'h1);
        cyc(1);
        rd(1'b1, ADDR_EDGE, v);
        chk("any_rise_cap", v, 32'h2);
        wr(1'b1, ADDR_EDGE, 32'h2);
        rd(1'b1, ADDR_EDGE, v);
        chk("any_cap_clr", v, 32'h0);
        in_b = 4'h0;
        cyc(1);
        chk("lvl_irq_hold", {31'h0, ib.irq}, 32'h1);
        cyc(1);
        chk("lvl_irq_low", {31'h0, ib.irq}, 32'h0);
        cyc(1);
        rd(1'b1, ADDR_EDGE, v);
        chk("any_fall_cap", v, 32'h2);
        chk("lvl_irq_cap_set", {31'h0, ib.irq}, 32'h0);
        rd(1'b1, ADDR_DATA, v);
        chk("b_data0", v, 32'h0);

        // Reset asserted mid-capture
        wr(1'b0, ADDR_MASK, 32'hF);
        in_a = 4'h0;
        cyc(3);
        in_a = 4'hF;
        ia.address = ADDR_EDGE;
        cyc(3);
        chk("pre_rst_irq", {31'h0, ia.irq}, 32'h1);
        cyc(1);
        chk("pre_rst_cap", ia.readdata, 32'hF);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_irq", {31'h0, ia.irq}, 32'h0);
        chk("async_rst_rdata", ia.readdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        rd(1'b0, ADDR_MASK, v);
        chk("rst_mask", v, 32'h0);
        rd(1'b0, ADDR_EDGE, v);
        chk("rst_cap", v, 32'h0);
        rd(1'b0, ADDR_DATA, v);
        chk("rst_data_f", v, 32'hF);
        cyc(3);
        rd(1'b0, ADDR_EDGE, v);
        chk("rst_no_spurious", v, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
